// File: rtl/wb_bram_slave.sv
// Wishbone B3 slave wrapping a single-port 32-bit block RAM.
// Classic transfers take one wait cycle. Incrementing bursts (CTI 010) run at one beat
// per cycle by prefetching the next word while the current beat is acknowledged.
module wb_bram_slave #(
  parameter int unsigned adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [2:0]  wb_cti_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam int unsigned Depth = 2 ** adr_width;

  typedef enum logic [1:0] {StIdle, StSingle, StBurst} state_e;

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q;
  logic [31:0]          mem [Depth];
  logic [adr_width-1:0] word;
  logic [adr_width-1:0] rd_adr;
  logic                 req;
  logic                 burst_req;
  logic                 wr_en;
  logic                 rd_en;
  logic                 unused_adr;

  // Upper address bits alias; byte offset bits are covered by wb_sel_i.
  assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  assign word      = wb_adr_i[adr_width+1:2];
  assign req       = wb_cyc_i & wb_stb_i;
  assign burst_req = req & (wb_cti_i == 3'b010);

  // State and acknowledge registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = (wb_cti_i == 3'b010) ? StBurst : StSingle;
        end
      end
      StSingle: state_d = StIdle;
      StBurst:  state_d = burst_req ? StBurst : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs and RAM port controls derived from the current and next state.
  always_comb begin
    ack_d  = (state_d != StIdle);
    // Only load the read register when the next cycle acknowledges, so wb_dat_o holds otherwise.
    rd_en  = (state_d != StIdle);
    // A beat completes only while ack is already high; reset clears ack_q, blocking the write.
    wr_en  = req & wb_we_i & ack_q;
    rd_adr = word;
    if (state_q == StBurst) begin
      rd_adr = word + {{(adr_width-1){1'b0}}, 1'b1};
    end
  end

  // RAM write port with per-byte enables.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem[word][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Synchronous RAM read port; read-before-write on a same-edge collision.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dat_q <= 32'h0;
    end else if (rd_en) begin
      dat_q <= mem[rd_adr];
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Directed bench for wb_bram_slave: a default-size instance and a 16-word instance
// share one bus so that address wrap can be observed on the small one.
module tb_wb_bram_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [2:0]  cti;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_o2;
  logic        ack2;

  int checks;
  int failures;

  wb_bram_slave #(.adr_width(11)) u_dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_cti_i (cti),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack)
  );

  wb_bram_slave #(.adr_width(4)) u_dut_small (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o2),
    .wb_cti_i (cti),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    cti   = 3'b000;
    sel   = 4'h0;
    adr   = 32'h0;
    dat_i = 32'h0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [2:0] c, input logic [3:0] s);
    cyc   = 1'b1;
    stb   = 1'b1;
    adr   = a;
    dat_i = d;
    we    = w;
    cti   = c;
    sel   = s;
  endtask

  // Classic write; bounded wait for ack.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    @(negedge clk);
    drive(a, d, 1'b1, 3'b000, s);
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wr_timeout adr=%h ack=%b required ack=1", a, ack);
    end
    @(negedge clk);
    bus_idle();
  endtask

  // Classic read; bounded wait for ack.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    d = 32'hx;
    @(negedge clk);
    drive(a, 32'h0, 1'b0, 3'b000, 4'hf);
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        d   = dat_o;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL rd_timeout adr=%h ack=%b required ack=1", a, ack);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    checks += 4;
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
    if (dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h want=0", dat_o); end
    if (ack2 !== 1'b0) begin failures++; $display("FAIL reset_ack2 got=%b want=0", ack2); end
    if (dat_o2 !== 32'h0) begin failures++; $display("FAIL reset_dat2 got=%h want=0", dat_o2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_classic_read();
    wr(32'h14, 32'hDEADBEEF, 4'hf);
    @(negedge clk);
    drive(32'h14, 32'h0, 1'b0, 3'b000, 4'hf);
    @(negedge clk);
    checks += 2;
    if (ack !== 1'b1) begin failures++; $display("FAIL classic_ack_c2 got=%b want=1", ack); end
    if (dat_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL classic_dat got=%h want=deadbeef", dat_o);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL classic_ack_c3 got=%b want=0", ack); end
    // Strobe held: the next classic transfer acks two cycles after the previous one.
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL classic_b2b_ack got=%b want=1", ack); end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_byte_lane();
    logic [31:0] d;
    wr(32'h0C, 32'h11223344, 4'hf);
    wr(32'h0C, 32'hAABBCCDD, 4'b0101);
    rd(32'h0C, d);
    checks++;
    if (d !== 32'h11BB33DD) begin failures++; $display("FAIL byte_lane got=%h want=11bb33dd", d); end
  endtask

  task automatic test_burst_read();
    logic [2:0] ctis [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
    for (int i = 0; i < 4; i++) wr(32'h20 + 32'(4 * i), 32'(i + 1), 4'hf);
    @(negedge clk);
    drive(32'h20, 32'h0, 1'b0, ctis[0], 4'hf);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (ack !== 1'b1) begin failures++; $display("FAIL burst_rd_ack%0d got=%b want=1", k, ack); end
      if (dat_o !== 32'(k + 1)) begin
        failures++; $display("FAIL burst_rd_dat%0d got=%h want=%h", k, dat_o, 32'(k + 1));
      end
      drive(32'h20 + 32'(4 * k), 32'h0, 1'b0, ctis[k], 4'hf);
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL burst_rd_end got=%b want=0", ack); end
    bus_idle();
  endtask

  task automatic test_burst_wait();
    logic [31:0] exp_d [5] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3,
                               32'h44444444};
    logic [31:0] d;
    for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'hFFFFFFFF, 4'hf);
    wr(32'h10, 32'h44444444, 4'hf);
    @(negedge clk);
    drive(32'h00, exp_d[0], 1'b1, 3'b010, 4'hf);
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL wait_beat1_ack got=%b want=1", ack); end
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL wait_beat2_ack got=%b want=1", ack); end
    drive(32'h04, exp_d[1], 1'b1, 3'b010, 4'hf);
    @(negedge clk);
    // Strobe dropped; a stray address/data pair must not reach the RAM.
    stb   = 1'b0;
    adr   = 32'h10;
    dat_i = 32'h0BAD0BAD;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL wait_gap_ack got=%b want=0", ack); end
    drive(32'h08, exp_d[2], 1'b1, 3'b010, 4'hf);
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL wait_resume_ack got=%b want=1", ack); end
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL wait_beat4_ack got=%b want=1", ack); end
    drive(32'h0C, exp_d[3], 1'b1, 3'b111, 4'hf);
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL wait_end_ack got=%b want=0", ack); end
    bus_idle();
    for (int i = 0; i < 5; i++) begin
      rd(32'(4 * i), d);
      checks++;
      if (d !== exp_d[i]) begin
        failures++; $display("FAIL wait_ram%0d got=%h want=%h", i, d, exp_d[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] adrs  [3] = '{32'h38, 32'h3C, 32'h00};
    logic [2:0]  ctis  [3] = '{3'b010, 3'b010, 3'b111};
    logic [31:0] exp_d [3] = '{32'h0000E014, 32'h0000E015, 32'h0000E000};
    for (int i = 0; i < 3; i++) wr(adrs[i], exp_d[i], 4'hf);
    @(negedge clk);
    drive(adrs[0], 32'h0, 1'b0, ctis[0], 4'hf);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (ack2 !== 1'b1) begin failures++; $display("FAIL wrap_ack%0d got=%b want=1", k, ack2); end
      if (dat_o2 !== exp_d[k]) begin
        failures++; $display("FAIL wrap_dat%0d got=%h want=%h", k, dat_o2, exp_d[k]);
      end
      drive(adrs[k], 32'h0, 1'b0, ctis[k], 4'hf);
    end
    @(negedge clk);
    checks++;
    if (ack2 !== 1'b0) begin failures++; $display("FAIL wrap_end got=%b want=0", ack2); end
    bus_idle();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    wr(32'h50, 32'h5A5A0014, 4'hf);
    wr(32'h54, 32'h5A5A0015, 4'hf);
    @(negedge clk);
    drive(32'h50, 32'hE1E1E1E1, 1'b1, 3'b010, 4'hf);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL rstb_beat2_ack got=%b want=1", ack); end
    drive(32'h54, 32'hE2E2E2E2, 1'b1, 3'b010, 4'hf);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL rstb_async_ack got=%b want=0", ack); end
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(32'h50, 32'h0, 1'b0, 3'b000, 4'hf);
    @(negedge clk);
    checks += 2;
    if (ack !== 1'b1) begin failures++; $display("FAIL rstb_read_ack got=%b want=1", ack); end
    if (dat_o !== 32'hE1E1E1E1) begin
      failures++; $display("FAIL rstb_beat1 got=%h want=e1e1e1e1", dat_o);
    end
    @(negedge clk);
    bus_idle();
    rd(32'h54, d);
    checks++;
    if (d !== 32'h5A5A0015) begin failures++; $display("FAIL rstb_beat2 got=%h want=5a5a0015", d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_classic_read();
    test_byte_lane();
    test_burst_read();
    test_burst_wait();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
